// File: rtl/hazard_pkg.sv
// Shared stage indices and the stall-source selection record used by hazard_control_unit.
package hazard_pkg;

    localparam int unsigned IF_ID  = 0;
    localparam int unsigned ID_EX  = 1;
    localparam int unsigned EX_MEM = 2;
    localparam int unsigned MEM_WB = 3;

    localparam int unsigned STAGE_IDX_W = 8;

    // Deepest active stall source; valid=0 stands for "no stall" (s_max = -1).
    typedef struct packed {
        logic                   valid;
        logic [STAGE_IDX_W-1:0] idx;
    } stall_sel_t;

    function automatic stall_sel_t stall_merge(input stall_sel_t cur,
                                               input logic active,
                                               input logic [STAGE_IDX_W-1:0] idx);
        stall_sel_t r;
        r = cur;
        if (active && (!cur.valid || (idx > cur.idx))) begin
            r.valid = 1'b1;
            r.idx   = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive cycles with the PC frozen and flags a stall that reaches MAX_STALL_CYCLES.
module stall_watchdog #(
    parameter int unsigned MAX_STALL_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pc_write_enable,
    output logic stall_timeout
);

    localparam int unsigned      CNT_W   = $clog2(MAX_STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL_CYCLES);

    logic [CNT_W-1:0] count;

    // Saturating counter; the flag follows a cycle later and drops as soon as the PC moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            stall_timeout <= 1'b0;
        end else if (pc_write_enable) begin
            count         <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
            stall_timeout <= (count == CNT_MAX);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/redirect controller with fetch-squash tracking and a stall watchdog.
// Optional perf counters (stall_cycles, redirect_count) are built when HAZARD_PERF_EN is defined.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES       = 5,
    parameter int unsigned IMEM_STAGE       = IF_ID,
    parameter int unsigned LOADUSE_STAGE    = ID_EX,
    parameter int unsigned MULDIV_STAGE     = EX_MEM,
    parameter int unsigned DMEM_STAGE       = MEM_WB,
    parameter int unsigned BRANCH_STAGE     = EX_MEM,
    parameter int unsigned MAX_STALL_CYCLES = 255,
    parameter int unsigned PERF_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use_hazard,
    input  logic                  imem_busy,
    input  logic                  muldiv_busy,
    input  logic                  dmem_busy,
    input  logic                  branch_hazard,
    output logic                  pc_write_enable,
    output logic                  pc_redirect_sel,
    output logic [NUM_STAGES-2:0] stage_enable,
    output logic [NUM_STAGES-2:0] stage_flush,
    output logic                  squash_pending,
    output logic                  stall_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     redirect_count
`endif
);

    localparam int unsigned NUM_REGS = NUM_STAGES - 1;
    localparam logic [STAGE_IDX_W-1:0] BR_IDX = STAGE_IDX_W'(BRANCH_STAGE);

    stall_sel_t s_max_c;
    logic       redirect_ok_c;

    // Deepest asserted stall source wins.
    always_comb begin
        s_max_c = '0;
        s_max_c = stall_merge(s_max_c, imem_busy,       STAGE_IDX_W'(IMEM_STAGE));
        s_max_c = stall_merge(s_max_c, load_use_hazard, STAGE_IDX_W'(LOADUSE_STAGE));
        s_max_c = stall_merge(s_max_c, muldiv_busy,     STAGE_IDX_W'(MULDIV_STAGE));
        s_max_c = stall_merge(s_max_c, dmem_busy,       STAGE_IDX_W'(DMEM_STAGE));
    end

    // A branch frozen behind an older stall simply retries next cycle.
    assign redirect_ok_c = rst_n && branch_hazard && (!s_max_c.valid || (s_max_c.idx < BR_IDX));

    always_comb begin
        pc_write_enable = 1'b1;
        pc_redirect_sel = 1'b0;
        stage_enable    = '1;
        stage_flush     = '0;
        if (!rst_n) begin
            pc_write_enable = 1'b0;
            stage_enable    = '0;
            stage_flush     = '1;
        end else begin
            if (s_max_c.valid) begin
                pc_write_enable = 1'b0;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    stage_enable[i] = (STAGE_IDX_W'(i) > s_max_c.idx);
                    stage_flush[i]  = (STAGE_IDX_W'(i) == s_max_c.idx);
                end
            end
            if (redirect_ok_c) begin
                pc_write_enable = 1'b1;
                pc_redirect_sel = 1'b1;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (i < BRANCH_STAGE) begin
                        stage_flush[i] = 1'b1;
                    end
                end
            end
            if (squash_pending && !imem_busy) begin
                stage_flush[0] = 1'b1;
            end
        end
    end

    // The fetch outstanding at redirect time returns a wrong-path instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_pending <= 1'b0;
        end else begin
            squash_pending <= imem_busy && (redirect_ok_c || squash_pending);
        end
    end

    stall_watchdog #(
        .MAX_STALL_CYCLES (MAX_STALL_CYCLES)
    ) u_stall_watchdog (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_write_enable (pc_write_enable),
        .stall_timeout   (stall_timeout)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (!pc_write_enable) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (redirect_ok_c) begin
                redirect_count <= redirect_count + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised successor to the pipeline stall/flush controller. It generalises to N pipeline stages with per-register enable/flush vectors and prioritises multiple stall sources by pipeline depth. It also adds two sequential behaviours: a pending-squash tracker for redirects taken while an instruction fetch is in flight, and a stall watchdog. It sits beside the datapath and drives the PC and every inter-stage register.

Parameters:
NUM_STAGES, 5, pipeline stages; there are NUM_STAGES-1 inter-stage registers, indexed 0 (IF/ID) upward.
IMEM_STAGE, 0, register receiving a bubble on imem_busy.
LOADUSE_STAGE, 1, register receiving a bubble on load_use_hazard.
MULDIV_STAGE, 2, register receiving a bubble on muldiv_busy.
DMEM_STAGE, 3, register receiving a bubble on dmem_busy.
BRANCH_STAGE, 2, stage resolving branches; registers 0..BRANCH_STAGE-1 hold younger instructions.
MAX_STALL_CYCLES, 255, watchdog threshold (>=1).
PERF_W, 32, perf counter width (optional feature).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_use_hazard  in  1  load-use dependency detected in ID.
imem_busy  in  1  instruction fetch outstanding.
muldiv_busy  in  1  multi-cycle EX operation incomplete.
dmem_busy  in  1  data memory access outstanding.
branch_hazard  in  1  taken branch/jump mispredict resolved in BRANCH_STAGE.
pc_write_enable  out  1  1 = PC updates this cycle.
pc_redirect_sel  out  1  1 = PC loads the branch target.
stage_enable  out  NUM_STAGES-1  per-register load enable.
stage_flush  out  NUM_STAGES-1  per-register bubble insert (overrides enable).
squash_pending  out  1  a stale fetch must be discarded on return.
stall_timeout  out  1  watchdog fired.

Behaviour:
- Reset (rst_n low, asynchronous):
  - squash_pending=0; watchdog count=0; stall_timeout=0.
  - pc_write_enable=0, pc_redirect_sel=0, stage_enable=0, stage_flush=all 1.
- Stall resolution (combinational): s_max = highest stage index among asserted stall sources; -1 if none.
  - If s_max>=0: pc_write_enable=0; stage_enable[i]=0 for i<s_max; stage_flush[s_max]=1; registers above s_max are enabled.
  - If no source is asserted: all enables=1, flushes=0, pc_write_enable=1.
- Redirect accepted when branch_hazard && s_max<BRANCH_STAGE:
  - pc_write_enable=1, pc_redirect_sel=1.
  - stage_flush[i]=1 for all i<BRANCH_STAGE. This overrides the younger-stage stalls.
- If branch_hazard && s_max>=BRANCH_STAGE: the redirect is not accepted and pc_redirect_sel=0. The branch stays frozen, re-asserts next cycle and is accepted then. No latching.
- Squash tracking:
  - Redirect accepted with imem_busy=1 sets squash_pending at the next edge.
  - While squash_pending=1 and imem_busy=0: stage_flush[0]=1 (stale instruction discarded), and squash_pending clears at that edge.
  - A second accepted redirect while pending keeps it set.
- Watchdog:
  - Counter increments each cycle pc_write_enable=0 and saturates at MAX_STALL_CYCLES.
  - The counter clears on any cycle with pc_write_enable=1.
  - stall_timeout = (count==MAX_STALL_CYCLES), registered.
- Reset asserted mid-squash or mid-stall clears all state immediately. After release the first cycle follows the combinational rules above.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[PERF_W-1:0] and redirect_count[PERF_W-1:0].
  - stall_cycles counts cycles with pc_write_enable=0; redirect_count counts accepted redirects.
  - Both wrap modulo 2^PERF_W and reset to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package hazard_pkg holds the default stage-index constants (IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3) and the stall-source encoding used for s_max.
- One sub-module, stall_watchdog: the counter plus timeout flag, parameterised by MAX_STALL_CYCLES.

Test Plan:
- load_use_hazard=1 only -> pc_write_enable=0, stage_enable=4'b1100, stage_flush=4'b0010.
- dmem_busy=1 with branch_hazard=1 for 3 cycles, then dmem_busy=0 -> no redirect while busy. The cycle busy drops: pc_redirect_sel=1, stage_flush=4'b0011.
- branch_hazard=1 with imem_busy=1, then imem_busy stays 1 for 2 cycles and drops -> squash_pending=1 for those cycles; stage_flush[0]=1 on the drop cycle; squash_pending=0 after.
- MAX_STALL_CYCLES=4, muldiv_busy held 6 cycles -> stall_timeout=1 from the 5th edge; clears the cycle after muldiv_busy falls.
- rst_n pulsed low while squash_pending=1 -> squash_pending=0 immediately; stage_flush=all 1 during reset.
- HAZARD_PERF_EN defined: 3 stall cycles + 2 redirects -> stall_cycles=3, redirect_count=2.
